// File: rtl/reg_dst_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
//   Shared types and constants for the destination-register scoreboard.
//   AW   : register address width (NREG = 2**AW architectural registers)
//   CW   : per-register outstanding-write counter width
//   CNT_MAX : saturation value of a counter (2**CW - 1)
//   REG_ZERO: the hard-wired zero register, never tracked
// -----------------------------------------------------------------------------
package scoreboard_pkg;

    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int NREG = 2 ** AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t      CNT_MAX  = '1;
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_dst_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_dst_scoreboard_if
//   Bundles the issue, writeback and source-query signals of the scoreboard.
//   master : issue/writeback/decode side (drives requests, reads status)
//   slave  : the scoreboard itself
//   Signals:
//     iss_valid/iss_dst/iss_ready : mark a destination register pending
//     wb_valid/wb_dst             : retire one outstanding write
//     rs_addr/rt_addr             : decode-stage source registers
//     rs_busy/rt_busy             : source has an outstanding write
//     stall, any_busy, wb_err     : pipeline stall, global busy, sticky error
// -----------------------------------------------------------------------------
interface reg_dst_scoreboard_if;
    import scoreboard_pkg::*;

    logic      iss_valid;
    reg_addr_t iss_dst;
    logic      iss_ready;
    logic      wb_valid;
    reg_addr_t wb_dst;
    reg_addr_t rs_addr;
    reg_addr_t rt_addr;
    logic      rs_busy;
    logic      rt_busy;
    logic      stall;
    logic      any_busy;
    logic      wb_err;

    modport master (
        output iss_valid, iss_dst, wb_valid, wb_dst, rs_addr, rt_addr,
        input  iss_ready, rs_busy, rt_busy, stall, any_busy, wb_err
    );

    modport slave (
        input  iss_valid, iss_dst, wb_valid, wb_dst, rs_addr, rt_addr,
        output iss_ready, rs_busy, rt_busy, stall, any_busy, wb_err
    );

endinterface

// File: rtl/reg_dst_scoreboard_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
//   One saturating up/down outstanding-write counter.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : one more write outstanding (ignored when full)
//     dec        : one write retired (ignored when zero)
//     cnt        : current count
//     full       : count is at CNT_MAX
//     nonzero    : at least one write outstanding
//     underflow  : dec requested while count is zero (combinational)
// -----------------------------------------------------------------------------
module sb_counter
    import scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic full,
    output logic nonzero,
    output logic underflow
);

    assign full      = (cnt == CNT_MAX);
    assign nonzero   = (cnt != '0);
    assign underflow = dec && !nonzero;

    // Simultaneous inc and dec cancel, so a saturated counter that is both
    // issued to and written back stays put rather than dipping and refilling.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + cnt_t'(1);
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - cnt_t'(1);
        end
    end

endmodule

// File: rtl/reg_dst_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_dst_scoreboard
//   Tracks outstanding writes per architectural register (r1..r31; r0 is
//   never tracked). Issue marks a destination pending, writeback retires it,
//   and the decode stage queries rs/rt busy status to drive a stall.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears all counters and wb_err
//     sb    : reg_dst_scoreboard_if.slave (issue, writeback, query, status)
//   Configuration:
//     SCOREBOARD_WB_BYPASS_EN - when defined, a writeback retiring the last
//     outstanding write to rs/rt releases busy in the same cycle (register
//     file writes before it reads). Undefined: release one cycle later.
// -----------------------------------------------------------------------------
module reg_dst_scoreboard
    import scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    reg_dst_scoreboard_if.slave  sb
);

    cnt_t [NREG-1:0] cnt_vec;
    logic [NREG-1:0] full_vec;
    logic [NREG-1:0] nz_vec;
    logic [NREG-1:0] uf_vec;

    logic iss_fire;
    logic wb_fire;
    logic rs_release;
    logic rt_release;
    logic err_q;

    // Register 0 has no counter: it always reads as empty and never errors.
    assign cnt_vec[0]  = '0;
    assign full_vec[0] = 1'b0;
    assign nz_vec[0]   = 1'b0;
    assign uf_vec[0]   = 1'b0;

    assign iss_fire = sb.iss_valid && sb.iss_ready && (sb.iss_dst != REG_ZERO);
    assign wb_fire  = sb.wb_valid && (sb.wb_dst != REG_ZERO);

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (iss_fire && (sb.iss_dst == reg_addr_t'(i))),
            .dec       (wb_fire  && (sb.wb_dst  == reg_addr_t'(i))),
            .cnt       (cnt_vec[i]),
            .full      (full_vec[i]),
            .nonzero   (nz_vec[i]),
            .underflow (uf_vec[i])
        );
    end

    // Same-cycle release: a writeback retiring the final outstanding write
    // to a queried source hides its busy bit before the counter updates.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs_release = 1'b0;
        rt_release = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        rs_release = sb.wb_valid && (sb.wb_dst == sb.rs_addr) &&
                     (cnt_vec[sb.rs_addr] == cnt_t'(1));
        rt_release = sb.wb_valid && (sb.wb_dst == sb.rt_addr) &&
                     (cnt_vec[sb.rt_addr] == cnt_t'(1));
`else
        rs_release = 1'b0;
        rt_release = 1'b0;
`endif
    end

    assign sb.iss_ready = !full_vec[sb.iss_dst];
    assign sb.rs_busy   = (cnt_vec[sb.rs_addr] != '0) && !rs_release;
    assign sb.rt_busy   = (cnt_vec[sb.rt_addr] != '0) && !rt_release;
    assign sb.stall     = sb.rs_busy || sb.rt_busy || (sb.iss_valid && !sb.iss_ready);
    assign sb.any_busy  = |nz_vec;
    assign sb.wb_err    = err_q;

    // Sticky: a writeback that finds no outstanding write means the pipeline
    // lost track of a destination (or retired across a reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|uf_vec) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_dst_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_dst_scoreboard
//   Self-checking bench for reg_dst_scoreboard: a directed vector table, a
//   hand-written asynchronous-reset sequence, and a randomized phase checked
//   against a per-register count model.
// -----------------------------------------------------------------------------
module tb_reg_dst_scoreboard;
    import scoreboard_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    reg_dst_scoreboard_if sb_if ();

    reg_dst_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      iv;
        reg_addr_t id;
        logic      wv;
        reg_addr_t wd;
        reg_addr_t rs;
        reg_addr_t rt;
        logic [5:0] exp;   // {iss_ready, rs_busy, rt_busy, stall, any_busy, wb_err}
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic iv, input int id, input logic wv, input int wd,
                                input int rs, input int rt, input logic [5:0] exp);
        vec_t v;
        v.iv = iv; v.id = reg_addr_t'(id);
        v.wv = wv; v.wd = reg_addr_t'(wd);
        v.rs = reg_addr_t'(rs); v.rt = reg_addr_t'(rt);
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {sb_if.iss_ready, sb_if.rs_busy, sb_if.rt_busy,
                sb_if.stall, sb_if.any_busy, sb_if.wb_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input reg_addr_t id, input logic wv, input reg_addr_t wd,
                         input reg_addr_t rs, input reg_addr_t rt);
        sb_if.iss_valid = iv;
        sb_if.iss_dst   = id;
        sb_if.wb_valid  = wv;
        sb_if.wb_dst    = wd;
        sb_if.rs_addr   = rs;
        sb_if.rt_addr   = rt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: outstanding-write count per register plus sticky error.
    int m_cnt [NREG];
    bit m_err;

    function automatic logic [5:0] model_outs(input logic iv, input int id, input logic wv,
                                              input int wd, input int rs, input int rt);
        logic rdy, rsb, rtb, anyb;
        int   max_out;
        max_out = (1 << CW) - 1;
        rdy  = (id == 0) || (m_cnt[id] != max_out);
        rsb  = (rs != 0) && (m_cnt[rs] > 0);
        rtb  = (rt != 0) && (m_cnt[rt] > 0);
        if (BYP) begin
            if (wv && wd == rs && m_cnt[rs] == 1) rsb = 1'b0;
            if (wv && wd == rt && m_cnt[rt] == 1) rtb = 1'b0;
        end
        anyb = 1'b0;
        for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) anyb = 1'b1;
        return {rdy, rsb, rtb, (rsb || rtb || (iv && !rdy)), anyb, m_err};
    endfunction

    task automatic model_step(input logic iv, input int id, input logic wv, input int wd);
        bit ifire, wfire;
        ifire = iv && (id != 0) && (m_cnt[id] != (1 << CW) - 1);
        wfire = wv && (wd != 0);
        if (wfire && m_cnt[wd] == 0) m_err = 1'b1;
        if (ifire && wfire && id == wd) begin
            // issue and retire on the same register cancel out
        end else begin
            if (ifire) m_cnt[id]++;
            if (wfire && m_cnt[wd] > 0) m_cnt[wd]--;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Directed table; state carries from row to row.
        vecs.push_back(mk(0, 0, 0,  0,  5, 0, 6'b100000));
        vecs.push_back(mk(1, 5, 0,  0,  5, 0, 6'b100000));
        vecs.push_back(mk(0, 0, 0,  0,  5, 0, 6'b110110));
        vecs.push_back(mk(0, 0, 1,  5,  5, 0, {1'b1, !BYP, 1'b0, !BYP, 2'b10}));
        vecs.push_back(mk(0, 0, 0,  0,  5, 0, 6'b100000));
        vecs.push_back(mk(1, 7, 0,  0,  0, 7, 6'b100000));
        vecs.push_back(mk(1, 7, 0,  0,  0, 7, 6'b101110));
        vecs.push_back(mk(1, 7, 0,  0,  0, 7, 6'b101110));
        vecs.push_back(mk(1, 7, 0,  0,  0, 7, 6'b001110));
        vecs.push_back(mk(1, 7, 0,  0,  0, 7, 6'b001110));
        vecs.push_back(mk(0, 7, 1,  7,  0, 7, 6'b001110));
        vecs.push_back(mk(0, 7, 0,  0,  0, 7, 6'b101110));
        vecs.push_back(mk(0, 0, 1,  7,  0, 0, 6'b100010));
        vecs.push_back(mk(0, 0, 1,  7,  0, 0, 6'b100010));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 6'b100000));
        vecs.push_back(mk(1, 9, 0,  0,  0, 9, 6'b100000));
        vecs.push_back(mk(1, 9, 1,  9,  0, 9, {2'b10, !BYP, !BYP, 2'b10}));
        vecs.push_back(mk(0, 0, 0,  0,  0, 9, 6'b101110));
        vecs.push_back(mk(0, 0, 1,  9,  0, 0, 6'b100010));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 6'b100000));
        vecs.push_back(mk(1, 0, 1,  0,  0, 0, 6'b100000));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 6'b100000));
        vecs.push_back(mk(0, 0, 1, 12, 12, 0, 6'b100000));
        vecs.push_back(mk(0, 0, 0,  0, 12, 0, 6'b100001));
        vecs.push_back(mk(0, 0, 0,  0, 12, 0, 6'b100001));

        do_reset();
        @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'(6'b100000));
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].wv, vecs[i].wd, vecs[i].rs, vecs[i].rt);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // Asynchronous reset in mid-cycle, then a stale writeback.
        do_reset();
        drive(1'b1, 5'd3, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        drive(1'b1, 5'd4, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        drive(1'b0, 5'd3, 1'b0, '0, 5'd3, 5'd4);
        @(negedge clk);
        check("pre_reset_busy", 32'(outs()), 32'(6'b111110));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'(6'b100000));
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 5'd3, 5'd3, '0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, '0, 5'd3, '0);
        @(negedge clk);
        check("stale_wb_err", 32'(outs()), 32'(6'b100001));

        // Randomized phase against the count model.
        do_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic iv, wv;
            int   id, wd, rs, rt;
            iv = ($urandom_range(0, 99) < 60);
            wv = ($urandom_range(0, 99) < 40);
            id = $urandom_range(0, 7);
            wd = $urandom_range(0, 7);
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            drive(iv, reg_addr_t'(id), wv, reg_addr_t'(wd), reg_addr_t'(rs), reg_addr_t'(rt));
            @(negedge clk);
            check($sformatf("rand%0d", c), 32'(outs()), 32'(model_outs(iv, id, wv, wd, rs, rt)));
            @(posedge clk); #1;
            model_step(iv, id, wv, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
